// File: rtl/nested_int_ctrl.sv
// nested_int_ctrl: parametrised nested-priority interrupt controller.
// Latches rising edges on the interrupt lines and presents the highest-priority
// unmasked pending source. A source is presented only when its priority is
// strictly above every source already in service. Sources being serviced are
// tracked as a nesting set, which is exported as running/cur_level.
// Source N_SRC-1 has the highest priority.
// Optional build macro NIC_SOFT_INT_EN adds the sw_set input. A pulse on
// sw_set[i] raises pending[i] in the same way as a hardware edge.
module nested_int_ctrl #(
  parameter int unsigned N_SRC                  = 3,
  parameter int unsigned VEC_W                  = 32,
  parameter logic [VEC_W-1:0] VEC_BASE          = VEC_W'(32'h0000_0100),
  parameter logic [VEC_W-1:0] VEC_STRIDE        = VEC_W'(32'h0000_0010),
  localparam int unsigned ID_W                  = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int unsigned LVL_W                 = $clog2(N_SRC + 1)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N_SRC-1:0]     int_req,
  input  logic [N_SRC-1:0]     int_mask,
  input  logic                 int_en,
  input  logic                 ack,
  input  logic                 eret,
`ifdef NIC_SOFT_INT_EN
  input  logic [N_SRC-1:0]     sw_set,
`endif
  output logic                 irq,
  output logic [ID_W-1:0]      vec_id,
  output logic [VEC_W-1:0]     vec_addr,
  output logic [N_SRC-1:0]     running,
  output logic [LVL_W-1:0]     cur_level
);

  // Index of the highest set bit. Returns 0 for an empty vector, so callers
  // must qualify the result with a non-empty test.
  function automatic logic [ID_W-1:0] hi_idx(input logic [N_SRC-1:0] v);
    logic [ID_W-1:0] r;
    r = {ID_W{1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      r = v[i] ? ID_W'(i) : r;
    end
    return r;
  endfunction

  // Nesting level of a running set: highest set index + 1. An empty set gives 0.
  function automatic logic [LVL_W-1:0] level_of(input logic [N_SRC-1:0] v);
    logic [LVL_W-1:0] r;
    r = {LVL_W{1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      r = v[i] ? LVL_W'(i + 1) : r;
    end
    return r;
  endfunction

  // One-hot decode of a source index.
  function automatic logic [N_SRC-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [N_SRC-1:0] r;
    r = {N_SRC{1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      r[i] = (ID_W'(i) == idx);
    end
    return r;
  endfunction

  logic [N_SRC-1:0] req_q, req_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] run_q, run_d;

  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] elig_s;
  logic [N_SRC-1:0] take_oh_s;
  logic [N_SRC-1:0] ret_oh_s;
  logic [ID_W-1:0]  sel_s;
  logic [ID_W-1:0]  top_s;
  logic [LVL_W-1:0] cur_level_s;
  logic [LVL_W-1:0] sel_level_s;
  logic             any_elig_s;
  logic             irq_s;
  logic             take_s;
  logic             ret_s;

  // Request sources: rising edges on the raw lines, plus optional software sets.
  always_comb begin
    edge_s = int_req & ~req_q;
`ifdef NIC_SOFT_INT_EN
    set_s  = edge_s | sw_set;
`else
    set_s  = edge_s;
`endif
  end

  // Arbitration: find the best eligible source and compare it with the
  // current nesting level.
  always_comb begin
    elig_s      = pend_q & ~int_mask;
    any_elig_s  = |elig_s;
    sel_s       = hi_idx(elig_s);
    cur_level_s = level_of(run_q);
    sel_level_s = LVL_W'(sel_s) + LVL_W'(1'b1);
    if (int_en && any_elig_s && (sel_level_s > cur_level_s)) begin
      irq_s = 1'b1;
    end else begin
      irq_s = 1'b0;
    end
  end

  // Handshake decode: an ack counts only while a source is presented, and an
  // eret counts only while some handler is in service.
  always_comb begin
    take_s = ack & irq_s;
    ret_s  = eret & (|run_q);
    top_s  = hi_idx(run_q);
    if (take_s) begin
      take_oh_s = onehot(sel_s);
    end else begin
      take_oh_s = {N_SRC{1'b0}};
    end
    if (ret_s) begin
      ret_oh_s = onehot(top_s);
    end else begin
      ret_oh_s = {N_SRC{1'b0}};
    end
  end

  // Next state. A new request that arrives on the source being acked is
  // OR-ed in after the clear, so that request is not lost. An eret retires
  // the old innermost handler, and a simultaneous ack adds the new one;
  // both use pre-edge state.
  always_comb begin
    req_d  = int_req;
    pend_d = (pend_q & ~take_oh_s) | set_s;
    run_d  = (run_q & ~ret_oh_s) | take_oh_s;
  end

  // State registers, cleared asynchronously by clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      req_q  <= {N_SRC{1'b0}};
      pend_q <= {N_SRC{1'b0}};
      run_q  <= {N_SRC{1'b0}};
    end else begin
      req_q  <= req_d;
      pend_q <= pend_d;
      run_q  <= run_d;
    end
  end

  // Outputs. The vector fields are zero whenever no interrupt is presented.
  always_comb begin
    irq       = irq_s;
    running   = run_q;
    cur_level = cur_level_s;
    if (irq_s) begin
      vec_id   = sel_s;
      vec_addr = VEC_BASE + (VEC_W'(sel_s) * VEC_STRIDE);
    end else begin
      vec_id   = {ID_W{1'b0}};
      vec_addr = {VEC_W{1'b0}};
    end
  end

endmodule
